// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack,
// and holds the fetched word for IF/ID while the pipeline is stalled.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_excepttype,
  output logic        stallreq_if
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_VALID   = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [31:0] EXC_ADEL = 32'h0000_0010;

  logic [1:0]  state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] ibuf, ibuf_n;
  logic [31:0] exc, exc_n;
  logic        pend, pend_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic [31:0] req_addr, req_addr_n;

  logic        aligned;
  logic        in_valid;
  logic        unused_stall;

  assign unused_stall = ^stall[5:1];
  assign aligned      = (pc[1:0] == 2'b00);
  assign in_valid     = (state == S_VALID);

  assign inst_req  = ((state == S_FETCH) && aligned)
                   || (state == S_DISCARD);
  assign inst_addr = req_addr;

  assign if_pc         = in_valid ? pc   : 32'd0;
  assign if_inst       = in_valid ? ibuf : 32'd0;
  assign if_excepttype = in_valid ? exc  : 32'd0;
  assign stallreq_if   = ~in_valid;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    ibuf_n    = ibuf;
    exc_n     = exc;
    pend_n    = pend;
    pend_pc_n = pend_pc;
    if (flush) begin
      pc_n   = new_pc;
      pend_n = 1'b0;
      exc_n  = 32'd0;
      // an issued request must complete before we refetch
      if (state == S_DISCARD)
        state_n = inst_ack ? S_FETCH : S_DISCARD;
      else if (state == S_FETCH && inst_req && !inst_ack)
        state_n = S_DISCARD;
      else
        state_n = S_FETCH;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          state_n = S_FETCH;
        end
        (state == S_FETCH): begin
          if (!aligned) begin
            ibuf_n  = 32'd0;
            exc_n   = EXC_ADEL;
            state_n = S_VALID;
          end else if (inst_ack) begin
            ibuf_n  = inst_rdata;
            exc_n   = 32'd0;
            state_n = S_VALID;
          end
        end
        (state == S_VALID): begin
          if (!stall[0]) begin
            if (branch_flag)
              pc_n = branch_target;
            else if (pend)
              pc_n = pend_pc;
            else
              pc_n = pc + 32'd4;
            pend_n  = 1'b0;
            state_n = S_FETCH;
          end
        end
        (state == S_DISCARD): begin
          if (inst_ack)
            state_n = S_FETCH;
        end
        default: state_n = S_IDLE;
      endcase
      // delay slot is in flight; remember where to go after it
      if (branch_flag && (!in_valid || stall[0])) begin
        pend_n    = 1'b1;
        pend_pc_n = branch_target;
      end
    end
    req_addr_n = (state_n == S_DISCARD) ? req_addr : pc_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ibuf     <= 32'd0;
      exc      <= 32'd0;
      pend     <= 1'b0;
      pend_pc  <= 32'd0;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ibuf     <= ibuf_n;
      exc      <= exc_n;
      pend     <= pend_n;
      pend_pc  <= pend_pc_n;
      req_addr <= req_addr_n;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed cycle-by-cycle vectors for if_fetch,
// plus a hand sequence for stall-time branch and flush in DISCARD.
module tb_if_fetch;

  localparam logic [31:0] R = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_excepttype;
  logic        stallreq_if;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .new_pc(new_pc), .branch_flag(branch_flag),
    .branch_target(branch_target), .inst_req(inst_req),
    .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rdata(inst_rdata), .if_pc(if_pc), .if_inst(if_inst),
    .if_excepttype(if_excepttype), .stallreq_if(stallreq_if)
  );

  typedef struct {
    logic        r, s, f;
    logic [31:0] np;
    logic        b;
    logic [31:0] bt;
    logic        a;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr, epc, einst, eexc;
    logic        estl;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic r, s, f, input logic [31:0] np,
    input logic b, input logic [31:0] bt,
    input logic a, input logic [31:0] rd,
    input logic ereq, input logic [31:0] eaddr, epc, einst, eexc,
    input logic estl);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.np = np;
    v.b = b; v.bt = bt; v.a = a; v.rd = rd;
    v.ereq = ereq; v.eaddr = eaddr; v.epc = epc;
    v.einst = einst; v.eexc = eexc; v.estl = estl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, f, input logic [31:0] np,
                       input logic b, input logic [31:0] bt,
                       input logic a, input logic [31:0] rd);
    rst = r; stall = {5'b0, s}; flush = f; new_pc = np;
    branch_flag = b; branch_target = bt;
    inst_ack = a; inst_rdata = rd;
  endtask

  task automatic expect_out(input string tag, input logic ereq,
                            input logic [31:0] eaddr, epc, einst, eexc,
                            input logic estl);
    chk({tag, " req"}, {31'd0, inst_req}, {31'd0, ereq});
    if (ereq)
      chk({tag, " addr"}, inst_addr, eaddr);
    chk({tag, " pc"}, if_pc, epc);
    chk({tag, " inst"}, if_inst, einst);
    chk({tag, " exc"}, if_excepttype, eexc);
    chk({tag, " stallreq"}, {31'd0, stallreq_if}, {31'd0, estl});
  endtask

  task automatic step(input string tag,
                      input logic s, f, input logic [31:0] np,
                      input logic b, input logic [31:0] bt,
                      input logic a, input logic [31:0] rd,
                      input logic ereq, input logic [31:0] eaddr,
                      input logic [31:0] epc, einst, eexc,
                      input logic estl);
    @(negedge clk);
    drive(1'b0, s, f, np, b, bt, a, rd);
    #1;
    expect_out(tag, ereq, eaddr, epc, einst, eexc, estl);
  endtask

  initial begin
    // r  s  f  new_pc  b  target  a  rdata | req addr pc inst exc stl
    tv.push_back(mk(1,0,0,0,0,0,0,0,             0,0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,             0,0,0,0,0,1));
    // zero-wait fetches, memory returns addr+1
    tv.push_back(mk(0,0,0,0,0,0,1,R+1,           1,R,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,             0,0,R,R+1,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,R+5,           1,R+4,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,             0,0,R+4,R+5,0,0));
    // three wait states at R+8
    tv.push_back(mk(0,0,0,0,0,0,0,32'hDEADBEEF,  1,R+8,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,32'hDEADBEEF,  1,R+8,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,32'hDEADBEEF,  1,R+8,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h1111_2222, 1,R+8,0,0,0,1));
    // stall[0] held for five cycles in VALID
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0,1,0,0,0,0,0,0,     0,0,R+8,32'h1111_2222,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,       0,0,R+8,32'h1111_2222,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h3333,      1,R+12,0,0,0,1));
    // flush from VALID to 0x8000_0000
    tv.push_back(mk(0,0,1,32'h8000_0000,0,0,0,0, 0,0,R+12,32'h3333,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'hA0,  1,32'h8000_0000,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,       0,0,32'h8000_0000,32'hA0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'hA4,  1,32'h8000_0004,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,       0,0,32'h8000_0004,32'hA4,0,0));
    // branch during fetch of the delay slot
    tv.push_back(mk(0,0,0,0,1,32'h8000_0100,0,0,
                    1,32'h8000_0008,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,1,32'hA8,  1,32'h8000_0008,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,       0,0,32'h8000_0008,32'hA8,0,0));
    // flush before ack: old address held until ack
    tv.push_back(mk(0,0,1,32'h8000_0180,0,0,0,0,
                    1,32'h8000_0100,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,       1,32'h8000_0100,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,1,32'hBAD0_BAD0,
                    1,32'h8000_0100,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,1,32'hC0,  1,32'h8000_0180,0,0,0,1));
    // branch to a misaligned target
    tv.push_back(mk(0,0,0,0,1,32'h8000_0102,0,0,
                    0,0,32'h8000_0180,32'hC0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,       0,0,0,0,0,1));
    tv.push_back(mk(0,0,1,32'h8000_0200,0,0,0,0,
                    0,0,32'h8000_0102,0,32'h10,0));
    // flush with ack and branch in the same cycle: flush wins
    tv.push_back(mk(0,0,1,32'h8000_0300,1,32'h8000_0400,1,32'hD0,
                    1,32'h8000_0200,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,1,32'hE0,  1,32'h8000_0300,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,       0,0,32'h8000_0300,32'hE0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'hE4,  1,32'h8000_0304,0,0,0,1));
    // reset beats flush
    tv.push_back(mk(1,0,1,32'h1234_5678,0,0,0,0,
                    0,0,32'h8000_0304,32'hE4,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,0,       0,0,0,0,0,1));
    // PC wrap past 0xFFFF_FFFC
    tv.push_back(mk(0,0,1,32'hFFFF_FFFC,0,0,1,32'h55,
                    1,R,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,1,32'hF0,  1,32'hFFFF_FFFC,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,0,0,       0,0,32'hFFFF_FFFC,32'hF0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h01,  1,32'h0,0,0,0,1));

    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].r, tv[i].s, tv[i].f, tv[i].np,
            tv[i].b, tv[i].bt, tv[i].a, tv[i].rd);
      #1;
      expect_out($sformatf("row%0d", i), tv[i].ereq, tv[i].eaddr,
                 tv[i].epc, tv[i].einst, tv[i].eexc, tv[i].estl);
    end

    // branch while stalled in VALID, then flushes inside DISCARD
    step("h1", 1, 0, 0, 1, 32'h8000_0500, 0, 0,
         0, 0, 32'h0, 32'h01, 0, 0);
    step("h2", 0, 0, 0, 0, 0, 0, 0,
         0, 0, 32'h0, 32'h01, 0, 0);
    step("h3", 0, 1, 32'h8000_0600, 0, 0, 0, 0,
         1, 32'h8000_0500, 0, 0, 0, 1);
    step("h4", 0, 1, 32'h8000_0700, 0, 0, 0, 0,
         1, 32'h8000_0500, 0, 0, 0, 1);
    step("h5", 0, 0, 0, 0, 0, 1, 32'hBAD,
         1, 32'h8000_0500, 0, 0, 0, 1);
    step("h6", 0, 0, 0, 0, 0, 1, 32'h77,
         1, 32'h8000_0700, 0, 0, 0, 1);
    step("h7", 0, 0, 0, 0, 0, 0, 0,
         0, 0, 32'h8000_0700, 32'h77, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that owns the program counter. It issues word fetches to instruction memory over a req/ack handshake and holds the fetched word while the pipeline is stalled. It applies branch redirects from ID and exception redirects from the exception controller. Its outputs feed the IF/ID pipeline register directly. While a fetch is outstanding it raises a stall request to the pipeline controller, which makes IF/ID insert NOPs.

## Interface
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  6  pipeline stall vector; only stall[0] (PC stage, 1 = stop) is used here.
- flush  in  1  exception flush; redirects the PC to new_pc.
- new_pc  in  32  exception handler address; valid when flush = 1.
- branch_flag  in  1  from ID: taken branch/jump in ID this cycle.
- branch_target  in  32  from ID: branch destination; valid when branch_flag = 1.
- inst_req  out  1  fetch request to instruction memory.
- inst_addr  out  32  fetch word address.
- inst_ack  in  1  memory completion; only meaningful while inst_req = 1.
- inst_rdata  in  32  fetched word; valid in the cycle inst_ack = 1.
- if_pc  out  32  PC of the presented instruction, to IF/ID.
- if_inst  out  32  presented instruction, to IF/ID.
- if_excepttype  out  32  exception flags; bit 4 = instruction address error (AdEL on fetch), all other bits 0.
- stallreq_if  out  1  to the pipeline controller: IF is not ready.

## Operation
- Registers: pc, ibuf (32), exc (32), pend (1), pend_pc (32), state.
- There are four states: IDLE, FETCH, VALID and DISCARD.
- Reset sets pc = RESET_PC, ibuf = 0, exc = 0, pend = 0 and state = IDLE. Reset has priority over every other input.
- IDLE: always moves to FETCH on the next edge.
- FETCH, aligned pc (pc[1:0] = 0):
  - Drive inst_req = 1 and inst_addr = pc.
  - On inst_ack: ibuf <= inst_rdata, exc <= 0, go to VALID.
- FETCH, misaligned pc:
  - inst_req stays 0.
  - Next edge: ibuf <= 0, exc[4] <= 1, go to VALID.
- VALID:
  - Present if_pc = pc, if_inst = ibuf, if_excepttype = exc.
  - If stall[0] = 1, hold everything.
  - Otherwise:
    - Next pc is branch_target if branch_flag = 1 this cycle; else pend_pc if pend = 1; else pc + 4, wrapping mod 2^32.
    - Clear pend and go to FETCH.
- Branch recorded outside VALID: if branch_flag = 1 in any non-VALID state, or in VALID with stall[0] = 1, set pend <= 1 and pend_pc <= branch_target.
  - The word currently being fetched is the delay slot and is kept.
  - A later branch_flag overwrites pend_pc.
- Flush: flush = 1 in any state sets pc <= new_pc and clears pend and exc. The next state depends on the fetch in progress:
  - In FETCH with inst_req = 1 and inst_ack = 0: go to DISCARD. pc still takes new_pc, but inst_addr keeps the old address; see DISCARD.
  - All other cases (including ack arriving in the flush cycle): go to FETCH, and the returned data is dropped.
- DISCARD:
  - Holds inst_req = 1 and inst_addr = the address latched when the request was issued (a separate 32-bit req_addr register).
  - On inst_ack, drop the data and go to FETCH for new_pc.
  - A further flush in DISCARD only updates pc.
- Simultaneous flush and branch_flag: flush wins, and the branch is dropped.
- Outputs in IDLE, FETCH and DISCARD: if_pc = 0, if_inst = 0, if_excepttype = 0.
- stallreq_if = 1 in IDLE, FETCH and DISCARD; 0 in VALID.
- Bus rule: while inst_req = 1 and inst_ack = 0, inst_addr must not change (inst_addr is driven from req_addr).

## Timing
- Outputs are decoded from registered state only, with no combinational path from inputs, except:
  - inst_req, which depends on state and pc alignment;
  - the pc-update mux.
- Zero-wait memory (ack in the same cycle as req): one instruction every 2 cycles (FETCH, VALID). Each wait state adds one cycle.
- After rst drops: IDLE for 1 cycle, FETCH in cycle 2 with inst_addr = RESET_PC.
- The first instruction appears on if_inst in the cycle after ack.
- A misaligned pc reaches VALID 1 cycle after entering FETCH, with no bus activity.
- Flush latency: the first request to new_pc is issued 1 cycle after flush, or 1 cycle after the outstanding ack if in DISCARD.

## Test plan
- Reset then zero-wait memory returning addr+1: inst_addr sequence BFC00000, BFC00004, …; if_inst presents BFC00001 in VALID; stallreq_if toggles 1,0.
- Memory with 3 wait states: inst_req and inst_addr stay constant for 4 cycles; stallreq_if = 1 throughout; ibuf is captured only on ack.
- stall[0] = 1 for 5 cycles in VALID: if_pc, if_inst and if_excepttype stay frozen, with no new request. Release → next address is pc + 4.
- branch_flag with target 0x8000_0100 during FETCH of 0x8000_0008: the delay slot at 0x8000_0008 is presented, then the next inst_addr is 0x8000_0100.
- flush with new_pc 0x8000_0180 mid-fetch, before ack: state DISCARD and the old address is held until ack; data is never presented; next inst_addr = 0x8000_0180.
- branch_target 0x8000_0102: no inst_req; VALID with if_excepttype = 0x10, if_inst = 0, if_pc = 0x8000_0102.
